fpmul_arbiter: RTL

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared floating-point multiplier.
// Define FPARB_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT_CYCLES with err=1.
module fpmul_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] opa_in,
  input  logic [63:0] opb_in,
  output logic [1:0]  done,
  output logic [31:0] res,
  output logic [5:0]  flags,
  output logic        err,
  output logic        busy,
  output logic        fpm_start,
  output logic [31:0] fpm_a,
  output logic [31:0] fpm_b,
  input  logic        fpm_done,
  input  logic [31:0] fpm_p,
  input  logic [5:0]  fpm_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        lastGrant_q, lastGrant_d;
  logic [31:0] fpmA_q, fpmA_d;
  logic [31:0] fpmB_q, fpmB_d;
  logic [31:0] res_q, res_d;
  logic [5:0]  flags_q, flags_d;
  logic        nextOwner;

`ifdef FPARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          err_q, err_d;
  logic          timeoutHit;

  assign timeoutHit = (waitCnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err        = err_q;
`else
  assign err = 1'b0;
`endif

  // When both ask, the requester that was not granted last time wins.
  always_comb begin
    if (req[0] && req[1]) nextOwner = ~lastGrant_q;
    else                  nextOwner = req[1];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    fpmA_d      = fpmA_q;
    fpmB_d      = fpmB_q;
    res_d       = res_q;
    flags_d     = flags_q;
`ifdef FPARB_TIMEOUT_EN
    waitCnt_d   = waitCnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = nextOwner;
          fpmA_d  = nextOwner ? opa_in[63:32] : opa_in[31:0];
          fpmB_d  = nextOwner ? opb_in[63:32] : opb_in[31:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef FPARB_TIMEOUT_EN
        waitCnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (fpm_done) begin
          res_d   = fpm_p;
          flags_d = fpm_flags;
`ifdef FPARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef FPARB_TIMEOUT_EN
        else if (timeoutHit) begin
          res_d   = '0;
          flags_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        lastGrant_d = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      fpmA_q      <= '0;
      fpmB_q      <= '0;
      res_q       <= '0;
      flags_q     <= '0;
`ifdef FPARB_TIMEOUT_EN
      waitCnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      fpmA_q      <= fpmA_d;
      fpmB_q      <= fpmB_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
`ifdef FPARB_TIMEOUT_EN
      waitCnt_q   <= waitCnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign fpm_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign fpm_a     = fpmA_q;
  assign fpm_b     = fpmB_q;
  assign res       = res_q;
  assign flags     = flags_q;

endmodule
